mat_key_ctrl: RTL

//   Controller between the debounced 4x4 keypad levels and the consumer logic.

---
 rtl/mat_key_if.sv | 23 ++
 rtl/mat_key_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mat_key_if.sv
// Key-code handshake between the keypad controller and its consumer.
// Valid/ready: a code transfers on a rising clk edge where key_valid and
// key_ready are both 1; while key_valid=1 and key_ready=0 the producer holds
// key_code stable, and key_valid never depends combinationally on key_ready.
interface mat_key_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    // Producer side: the keypad controller.
    modport master (
        output key_valid,
        output key_code,
        input  key_ready
    );

    // Consumer side: downstream logic reading key codes.
    modport slave (
        input  key_valid,
        input  key_code,
        output key_ready
    );
endinterface

// File: rtl/mat_key_ctrl.sv
// 4x4 keypad controller: scan strobe generation, press-edge detection on
// all 16 keys, fixed-priority serialisation of simultaneous presses and a
// small key-code FIFO read through the mat_key_if valid/ready handshake.
module mat_key_ctrl #(
    parameter int CLK_DIV    = 50000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             scan_en,
    input  logic [15:0]      btn_lvl,
    mat_key_if.master        kif,
    output logic [15:0]      pending,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PTR_MAX   = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    // Scan divider state.
    logic [DW-1:0] div_cnt;

    // Edge detection and arbitration.
    logic [15:0]   prev_lvl;
    logic [15:0]   press;
    logic [15:0]   grant;
    logic [15:0]   pending_nxt;
    logic [3:0]    grant_idx;
    logic          push_ok;
    logic          push;
    logic          pop;
    logic          lost_press;

    // Key-code queue.
    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Divider counts 0..CLK_DIV-1; the strobe is registered so it rises on
    // the edge where the counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            scan_en <= 1'b0;
        end else begin
            scan_en <= (div_cnt == DIV_MAX);
            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Press edges are taken every cycle; prev resets to all-ones so keys
    // held through reset stay silent until released and pressed again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_lvl <= 16'hFFFF;
        end else begin
            prev_lvl <= btn_lvl;
        end
    end

    assign press = btn_lvl & ~prev_lvl;

    // Queue handshake terms; pop only depends on registered valid.
    assign pop     = kif.key_valid & kif.key_ready;
    assign push_ok = (count < CNT_FULL) || pop;

    // Fixed priority: the lowest-numbered pending key wins the single push
    // slot. Only registered pending is considered, so a fresh press always
    // spends one cycle in pending before it can be granted.
    always_comb begin
        grant_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending[i]) begin
                grant_idx = 4'(i);
            end
        end
    end

    // One-hot grant, suppressed when the queue cannot accept a code.
    always_comb begin
        grant = 16'h0000;
        if (push_ok && (pending != 16'h0000)) begin
            grant = 16'h0001 << grant_idx;
        end
    end

    assign push        = (grant != 16'h0000);
    assign pending_nxt = (pending & ~grant) | press;
    // A repeat press on a key still waiting for a slot cannot be recorded.
    assign lost_press  = |(press & pending & ~grant);

    // Pending set and sticky overflow; a new loss wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 16'h0000;
            overflow <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (lost_press) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Queue storage: written at the write pointer on every push. When the
    // queue is full and popping, wr_ptr equals rd_ptr and the head slot is
    // reused after its code has been handed over this same cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= grant_idx;
        end
    end

    // Pointers wrap modulo FIFO_DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head presentation; reads as zero whenever the queue is empty.
    always_comb begin
        kif.key_valid = (count != '0);
        kif.key_code  = 4'd0;
        if (count != '0) begin
            kif.key_code = fifo_mem[rd_ptr];
        end
    end

endmodule
